// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle RV32I control FSM.
// ILLEGAL_TRAP_EN adds the TRAP state and routes illegal opcodes to it.
package ctrl_pkg;

    localparam int OP_WIDTH     = 7;
    localparam int ALU_OP_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_WIDTH-1:0] OP_STORE = 7'b0100011;
    localparam logic [OP_WIDTH-1:0] OP_R     = 7'b0110011;
    localparam logic [OP_WIDTH-1:0] OP_I     = 7'b0010011;
    localparam logic [OP_WIDTH-1:0] OP_BR    = 7'b1100011;
    localparam logic [OP_WIDTH-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_WIDTH-1:0] OP_JALR  = 7'b1100111;
    localparam logic [OP_WIDTH-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OP_WIDTH-1:0] OP_AUIPC = 7'b0010111;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_RI    = 3'b010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI   = 3'b100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AUIPC = 3'b101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_JL    = 3'b110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_4     = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
        S_EXEC_I, S_BRANCH, S_JALR, S_LINK, S_LUI, S_AUIPC, S_ALUWB
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    typedef enum logic [3:0] {
        CL_MEM, CL_R, CL_I, CL_BR, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILL
    } op_class_t;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t S_ILL_NEXT = S_TRAP;
`else
    localparam state_t S_ILL_NEXT = S_FETCH;
`endif

endpackage

// File: rtl/op_class_decoder.sv
// op_class_decoder: maps the IR opcode to an instruction class for DECODE.
module op_class_decoder
    import ctrl_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op_i,
    output op_class_t           cls_o
);

    always_comb begin
        cls_o = CL_ILL;
        case (op_i)
            OP_LOAD, OP_STORE: cls_o = CL_MEM;
            OP_R:              cls_o = CL_R;
            OP_I:              cls_o = CL_I;
            OP_BR:             cls_o = CL_BR;
            OP_JAL:            cls_o = CL_JAL;
            OP_JALR:           cls_o = CL_JALR;
            OP_LUI:            cls_o = CL_LUI;
            OP_AUIPC:          cls_o = CL_AUIPC;
            default:           cls_o = CL_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM of the multi-cycle RV32I core.
// ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state instead of acting as NOPs.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_WIDTH-1:0]     op,
    input  logic                    branch_taken,
    input  logic                    mem_ready,
    output logic                    pc_write,
    output logic                    adr_src,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic [1:0]              result_src,
    output logic [1:0]              alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [ALU_OP_WIDTH-1:0] ALUOp,
    output logic                    reg_write,
    output logic                    instr_done,
    output logic                    illegal_instr
);

    state_t    state_q, state_d;
    logic      done_q, done_d;
    op_class_t cls;
    logic      pc_w, ir_w, mem_w, reg_w;

    op_class_decoder u_dec (.op_i(op), .cls_o(cls));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        ALUOp      = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_4;
                result_src = RES_ALURES;
                pc_w       = mem_ready;
                ir_w       = mem_ready;
                state_d    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (cls)
                    CL_MEM:   state_d = S_MEMADR;
                    CL_R:     state_d = S_EXEC_R;
                    CL_I:     state_d = S_EXEC_I;
                    CL_BR:    state_d = S_BRANCH;
                    CL_JAL:   state_d = S_LINK;
                    CL_JALR:  state_d = S_JALR;
                    CL_LUI:   state_d = S_LUI;
                    CL_AUIPC: state_d = S_AUIPC;
                    default:  state_d = S_ILL_NEXT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_w      = 1'b1;
                done_d     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                done_d  = mem_ready;
                state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                ALUOp     = ALU_RI;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                ALUOp     = ALU_RI;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_b = SRCB_IMM;
                ALUOp     = ALU_LUI;
                state_d   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                ALUOp     = ALU_AUIPC;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                ALUOp     = ALU_SUB;
                pc_w      = branch_taken;
                done_d    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = S_LINK;
            end
            S_LINK: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_4;
                ALUOp     = ALU_JL;
                pc_w      = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = state_q;
        endcase
    end

    // Write enables are gated by rst so an abort drops them in the same cycle.
    assign pc_write   = pc_w & ~rst;
    assign ir_write   = ir_w & ~rst;
    assign mem_write  = mem_w & ~rst;
    assign reg_write  = reg_w & ~rst;
    assign instr_done = done_q;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state_q == S_TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed checks of the multi-cycle control FSM outputs.
// Honours ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] ALUOp;
    logic [15:0] outs;
    int tests = 0;
    int failed = 0;

    // Field order: {pc,adr,mw,ir}, result_src, alu_src_a, alu_src_b, ALUOp, {reg_write,done,illegal}
    localparam logic [15:0] F1  = {4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
    localparam logic [15:0] F1D = {4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 3'b010};
    localparam logic [15:0] F0  = {4'b0000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
    localparam logic [15:0] DEC = {4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000};
    localparam logic [15:0] EXR = {4'b0000, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000};
    localparam logic [15:0] EXI = {4'b0000, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000};
    localparam logic [15:0] LUI = {4'b0000, 2'b00, 2'b00, 2'b01, 3'b100, 3'b000};
    localparam logic [15:0] AUI = {4'b0000, 2'b00, 2'b01, 2'b01, 3'b101, 3'b000};
    localparam logic [15:0] AWB = {4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b100};
    localparam logic [15:0] MAD = {4'b0000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000};
    localparam logic [15:0] MRD = {4'b0100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [15:0] MWB = {4'b0000, 2'b01, 2'b00, 2'b00, 3'b000, 3'b100};
    localparam logic [15:0] MWR = {4'b0110, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [15:0] BRT = {4'b1000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000};
    localparam logic [15:0] BRN = {4'b0000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000};
    localparam logic [15:0] JLR = {4'b0000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000};
    localparam logic [15:0] LNK = {4'b1000, 2'b00, 2'b01, 2'b10, 3'b110, 3'b000};
    localparam logic [15:0] TRP = {4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001};

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst(rst), .op(op), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
        .reg_write(reg_write), .instr_done(instr_done), .illegal_instr(illegal_instr)
    );

    assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                   ALUOp, reg_write, instr_done, illegal_instr};

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        tests++;
        if (outs !== F0) begin failed++; $display("FAIL reset_hold: got %h expected %h", outs, F0); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (outs !== F1) begin failed++; $display("FAIL reset_release: got %h expected %h", outs, F1); end
        @(negedge clk);
    endtask

    task automatic test_r_type();
        logic [15:0] e [6] = '{F1, DEC, EXR, AWB, F1D, DEC};
        do_reset();
        op = 7'b0110011;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL r_type step %0d: got %h expected %h", i, outs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_stall();
        logic [15:0] e [8] = '{F1, DEC, MAD, MRD, MRD, MRD, MWB, F1D};
        logic m [8] = '{1, 1, 1, 0, 0, 1, 1, 1};
        do_reset();
        op = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = m[i];
            #1;
            tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL load_stall step %0d: got %h expected %h", i, outs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [15:0] e [7] = '{F1, DEC, BRT, F1D, DEC, BRN, F1D};
        logic b [7] = '{1, 1, 1, 0, 0, 0, 0};
        do_reset();
        op = 7'b1100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            branch_taken = b[i];
            #1;
            tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL branch step %0d: got %h expected %h", i, outs, e[i]); end
            @(negedge clk);
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_jalr();
        logic [15:0] e [6] = '{F1, DEC, JLR, LNK, AWB, F1D};
        do_reset();
        op = 7'b1100111;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL jalr step %0d: got %h expected %h", i, outs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_store_abort();
        logic [15:0] e [6] = '{F0, F1, DEC, MAD, MWR, MWR};
        logic m [6] = '{0, 1, 1, 1, 0, 0};
        do_reset();
        op = 7'b0100011;
        for (int i = 0; i < 6; i++) begin
            mem_ready = m[i];
            #1;
            tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL store_abort step %0d: got %h expected %h", i, outs, e[i]); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (outs !== F0) begin failed++; $display("FAIL abort_in_reset: got %h expected %h", outs, F0); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (outs !== F1) begin failed++; $display("FAIL abort_release: got %h expected %h", outs, F1); end
        @(negedge clk);
        #1;
        tests++;
        if (outs !== DEC) begin failed++; $display("FAIL abort_no_done: got %h expected %h", outs, DEC); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] e [22] = '{F1, DEC, MAD, MWR, MWR, F1D, DEC, EXI, AWB, F1D, DEC,
                                LUI, AWB, F1D, DEC, AUI, AWB, F1D, DEC, LNK, AWB, F1D};
        logic m [22] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        logic [6:0] o [22] = '{7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011,
                               7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011,
                               7'b0110111, 7'b0110111, 7'b0110111, 7'b0110111,
                               7'b0010111, 7'b0010111, 7'b0010111, 7'b0010111,
                               7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
        do_reset();
        for (int i = 0; i < 22; i++) begin
            mem_ready = m[i];
            op = o[i];
            #1;
            tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL back_to_back step %0d: got %h expected %h", i, outs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
        logic [15:0] e [5] = '{F1, DEC, TRP, TRP, TRP};
`else
        logic [15:0] e [5] = '{F1, DEC, F1, DEC, F1};
`endif
        do_reset();
        op = 7'b1111111;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (outs !== e[i]) begin failed++; $display("FAIL illegal step %0d: got %h expected %h", i, outs, e[i]); end
            @(negedge clk);
        end
        do_reset();
        #1;
        tests++;
        if (outs !== F1) begin failed++; $display("FAIL illegal_exit: got %h expected %h", outs, F1); end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_stall();
        test_branch();
        test_jalr();
        test_store_abort();
        test_back_to_back();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
